// File: rtl/register_file_pkg.sv
// Shared defaults and helpers for the register file.
// Tap indices and bank sizing live here.
package register_file_pkg;

    localparam int RF_DATA_WIDTH = 8;
    localparam int RF_ADDR_WIDTH = 3;

    localparam int RF_PC_ADDR   = 0;
    localparam int RF_DPTR_ADDR = 2;
    localparam int RF_ACC_ADDR  = 3;
    localparam int RF_TEMP_ADDR = 5;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/rf_shadow_bank.sv
// DEPTH x DATA_WIDTH register bank.
// Whole-bank parallel load, parallel output.
module rf_shadow_bank
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = rf_depth(RF_ADDR_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] load_data,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] bank
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] bank_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] bank_q;

    // Select next bank contents: hold or load all entries
    always_comb begin
        bank_d = bank_q;
        if (load) begin
            bank_d = load_data;
        end
    end

    // Bank storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank = bank_q;

endmodule

// File: rtl/register_file.sv
// Two-read one-write register file with PC increment,
// optional write bypass and a shadow bank for save/restore/swap.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1,
    parameter int PC_ADDR    = RF_PC_ADDR,
    parameter int DPTR_ADDR  = RF_DPTR_ADDR,
    parameter int ACC_ADDR   = RF_ACC_ADDR,
    parameter int TEMP_ADDR  = RF_TEMP_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    input  logic                  pc_inc,
    input  logic                  save,
    input  logic                  restore,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] DPTR,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] TEMP,
    output logic                  shadow_valid
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] live;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] live_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] shadow;
    logic                             shadow_valid_d;
    logic                             shadow_valid_q;

    // Live-bank next state: restore beats write beats increment
    always_comb begin
        live_d = live;
        if (restore) begin
            live_d = shadow;
        end else begin
            if (pc_inc) begin
                live_d[PC_ADDR] = live[PC_ADDR] + DATA_WIDTH'(1);
            end
            if (wr_en) begin
                live_d[w_addr] = w_data;
            end
        end
    end

    rf_shadow_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_live (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b1),
        .load_data (live_d),
        .bank      (live)
    );

    // Shadow samples the pre-edge live bank, so save+restore swaps
    rf_shadow_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .load      (save),
        .load_data (live),
        .bank      (shadow)
    );

    // Sticky flag once any save has landed
    always_comb begin
        shadow_valid_d = shadow_valid_q | save;
    end

    // Shadow-valid flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
        end
    end

    // Read ports with optional same-cycle write forwarding
    always_comb begin
        busA = live[ra_addr];
        busB = live[rb_addr];
        if (BYPASS && wr_en && !restore) begin
            if (ra_addr == w_addr) begin
                busA = w_data;
            end
            if (rb_addr == w_addr) begin
                busB = w_data;
            end
        end
    end

    assign PC           = live[PC_ADDR];
    assign DPTR         = live[DPTR_ADDR];
    assign A            = live[ACC_ADDR];
    assign TEMP         = live[TEMP_ADDR];
    assign shadow_valid = shadow_valid_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// A bypassed and a non-bypassed instance share stimulus.
module tb_register_file;

    logic       clk = 1'b0;
    logic       rst, wr_en, pc_inc, save, restore;
    logic [2:0] w_addr, ra_addr, rb_addr;
    logic [7:0] w_data;

    logic [7:0] busA, busB, PC, DPTR, A, TEMP;
    logic       sv;
    logic [7:0] n_busA, n_busB, n_PC, n_DPTR, n_A, n_TEMP;
    logic       n_sv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .pc_inc(pc_inc), .save(save), .restore(restore),
        .busA(busA), .busB(busB), .PC(PC), .DPTR(DPTR), .A(A),
        .TEMP(TEMP), .shadow_valid(sv)
    );

    register_file #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .pc_inc(pc_inc), .save(save), .restore(restore),
        .busA(n_busA), .busB(n_busB), .PC(n_PC), .DPTR(n_DPTR), .A(n_A),
        .TEMP(n_TEMP), .shadow_valid(n_sv)
    );

    task automatic idle();
        rst = 0; wr_en = 0; pc_inc = 0; save = 0; restore = 0;
        w_addr = 0; w_data = 0; ra_addr = 0; rb_addr = 0;
    endtask

    // Advance one edge, then release strobes
    task automatic step();
        @(posedge clk);
        #1;
        rst = 0; wr_en = 0; pc_inc = 0; save = 0; restore = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; wr_en = 1; w_addr = 3; w_data = 8'h5A;
        step();
        rst = 1;
        step();
        n_checks++;
        if (PC !== 8'h00 || DPTR !== 8'h00 || A !== 8'h00 || TEMP !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_taps got %h %h %h %h want 00", PC, DPTR, A, TEMP);
        end
        n_checks++;
        if (sv !== 1'b0 || n_sv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sv got %b/%b want 0", sv, n_sv);
        end
        ra_addr = 3; rb_addr = 7; #1;
        n_checks++;
        if (busA !== 8'h00 || busB !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus got %h %h want 00", busA, busB);
        end
    endtask

    task automatic test_write();
        wr_en = 1; w_addr = 3; w_data = 8'hFF; ra_addr = 0; rb_addr = 0;
        step();
        n_checks++;
        if (A !== 8'hFF) begin
            n_fail++;
            $display("FAIL write_acc got %h want ff", A);
        end
        n_checks++;
        if (PC !== 8'h00 || DPTR !== 8'h00 || TEMP !== 8'h00 || sv !== 1'b0) begin
            n_fail++;
            $display("FAIL write_others got %h %h %h sv=%b want 00 0", PC, DPTR, TEMP, sv);
        end
        ra_addr = 3; rb_addr = 3; #1;
        n_checks++;
        if (busA !== 8'hFF || n_busB !== 8'hFF) begin
            n_fail++;
            $display("FAIL write_read got %h %h want ff", busA, n_busB);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; w_addr = 5; w_data = 8'h20; ra_addr = 5; rb_addr = 5;
        #1;
        n_checks++;
        if (busA !== 8'h20 || busB !== 8'h20) begin
            n_fail++;
            $display("FAIL bypass_on got %h %h want 20", busA, busB);
        end
        n_checks++;
        if (n_busA !== 8'h00 || n_busB !== 8'h00) begin
            n_fail++;
            $display("FAIL bypass_off got %h %h want 00", n_busA, n_busB);
        end
        n_checks++;
        if (TEMP !== 8'h00) begin
            n_fail++;
            $display("FAIL bypass_tap_early got %h want 00", TEMP);
        end
        step();
        n_checks++;
        if (TEMP !== 8'h20 || n_TEMP !== 8'h20) begin
            n_fail++;
            $display("FAIL bypass_tap_late got %h %h want 20", TEMP, n_TEMP);
        end
    endtask

    task automatic test_pc_inc();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'hFF; exp_pc[1] = 8'h00; exp_pc[2] = 8'h01;
        wr_en = 1; w_addr = 0; w_data = 8'hFE;
        step();
        for (int i = 0; i < 3; i++) begin
            pc_inc = 1;
            #1;
            n_checks++;
            if (busA !== 8'h20 && ra_addr == 3'd5) begin
                n_fail++;
                $display("FAIL pc_no_bypass got %h want 20", busA);
            end
            step();
            n_checks++;
            if (PC !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL pc_inc_%0d got %h want %h", i, PC, exp_pc[i]);
            end
        end
        pc_inc = 1; wr_en = 1; w_addr = 0; w_data = 8'h40;
        step();
        n_checks++;
        if (PC !== 8'h40) begin
            n_fail++;
            $display("FAIL pc_write_wins got %h want 40", PC);
        end
        pc_inc = 1; wr_en = 1; w_addr = 1; w_data = 8'h33;
        step();
        ra_addr = 1; #1;
        n_checks++;
        if (PC !== 8'h41 || busA !== 8'h33) begin
            n_fail++;
            $display("FAIL pc_parallel got %h %h want 41 33", PC, busA);
        end
    endtask

    task automatic test_save_restore();
        wr_en = 1; w_addr = 2; w_data = 8'h04;
        step();
        save = 1; wr_en = 1; w_addr = 2; w_data = 8'h99;
        step();
        n_checks++;
        if (DPTR !== 8'h99 || sv !== 1'b1) begin
            n_fail++;
            $display("FAIL save_write got %h sv=%b want 99 1", DPTR, sv);
        end
        restore = 1; wr_en = 1; w_addr = 2; w_data = 8'h77;
        pc_inc = 1; ra_addr = 2;
        #1;
        n_checks++;
        if (busA !== 8'h99) begin
            n_fail++;
            $display("FAIL restore_no_bypass got %h want 99", busA);
        end
        step();
        n_checks++;
        if (DPTR !== 8'h04 || PC !== 8'h41 || A !== 8'hFF || TEMP !== 8'h20) begin
            n_fail++;
            $display("FAIL restore got %h %h %h %h want 41 04 ff 20", PC, DPTR, A, TEMP);
        end
    endtask

    task automatic test_swap();
        wr_en = 1; w_addr = 3; w_data = 8'h22;
        step();
        save = 1;
        step();
        wr_en = 1; w_addr = 3; w_data = 8'h11;
        step();
        save = 1; restore = 1; wr_en = 1; w_addr = 3; w_data = 8'hEE;
        step();
        n_checks++;
        if (A !== 8'h22 || sv !== 1'b1) begin
            n_fail++;
            $display("FAIL swap got %h sv=%b want 22 1", A, sv);
        end
        restore = 1;
        step();
        n_checks++;
        if (A !== 8'h11) begin
            n_fail++;
            $display("FAIL swap_back got %h want 11", A);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1; save = 1; wr_en = 1; w_addr = 3; w_data = 8'hAA;
        step();
        n_checks++;
        if (PC !== 8'h00 || DPTR !== 8'h00 || A !== 8'h00 || TEMP !== 8'h00 || sv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got %h %h %h %h sv=%b want 0", PC, DPTR, A, TEMP, sv);
        end
        wr_en = 1; w_addr = 3; w_data = 8'h5C;
        step();
        restore = 1;
        step();
        n_checks++;
        if (A !== 8'h00 || n_A !== 8'h00 || sv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_restore got %h %h sv=%b want 00 0", A, n_A, sv);
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_write();
        test_bypass();
        ra_addr = 5;
        test_pc_inc();
        test_save_restore();
        test_swap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
